// File: rtl/cache_fill_fsm_pkg.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_pkg
// Shared constants for the cache-miss fill controller:
//   - FSM state encoding (IDLE / FILL, one state flop)
//   - CHUNKS      : number of 2-byte reads per 16-byte block
//   - CHUNK_IDX_W : width of a word index inside the block
//   - OFFSET_W    : block-offset bits of a byte address
//   - BLOCK_MASK  : clears the block offset of a 16-bit byte address
// No ports (package).
// -----------------------------------------------------------------------------
package cache_fill_fsm_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam int CHUNKS      = 8;
    localparam int CHUNK_IDX_W = 3;
    localparam int OFFSET_W    = 4;

    localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm_if
// Bundles the cache-side and memory-side signals of the fill controller.
//   miss_detected     : cache lookup missed this cycle (level)
//   miss_address      : byte address of the missing access
//   memory_data_valid : one returned memory word present this cycle
//   fsm_busy          : fill in progress, pipeline stalls
//   memory_read       : read request to memory this cycle
//   memory_address    : byte address of the current read request
//   write_data_array  : write the returned word into the data array
//   data_array_word   : word index within the block for that write
//   write_tag_array   : write tag and set valid (last word)
// Modports:
//   master : the fill controller (drives requests and array strobes)
//   slave  : the surrounding cache / memory environment
// -----------------------------------------------------------------------------
interface cache_fill_fsm_if
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W = 16
);

    logic                   miss_detected;
    logic [ADDR_W-1:0]      miss_address;
    logic                   memory_data_valid;
    logic                   fsm_busy;
    logic                   memory_read;
    logic [ADDR_W-1:0]      memory_address;
    logic                   write_data_array;
    logic [CHUNK_IDX_W-1:0] data_array_word;
    logic                   write_tag_array;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        output fsm_busy,
        output memory_read,
        output memory_address,
        output write_data_array,
        output data_array_word,
        output write_tag_array
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        input  fsm_busy,
        input  memory_read,
        input  memory_address,
        input  write_data_array,
        input  data_array_word,
        input  write_tag_array
    );

endinterface

// File: rtl/cache_fill_fsm_chunk_counter_3b.sv
// -----------------------------------------------------------------------------
// chunk_counter_3b
// 3-bit chunk index counter built on a 3-bit ripple adder (B = 3'b001).
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset, count -> 0
//   clear  : synchronous clear, highest priority after reset
//   enable : advance count by one
//   count  : current index
//   wrap   : adder carry-out, high while count is 7 (next step wraps to 0)
// -----------------------------------------------------------------------------
module chunk_counter_3b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] count,
    output logic       wrap
);

    localparam logic [2:0] INCREMENT = 3'b001;

    logic [2:0] sum;
    logic [3:0] carry;

    // Ripple adder: each stage is a full adder fed by the previous carry.
    // The final carry doubles as the wrap flag, so no separate compare is needed.
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < 3; i++) begin : g_ripple
        assign sum[i]     = count[i] ^ INCREMENT[i] ^ carry[i];
        assign carry[i+1] = (count[i] & INCREMENT[i]) | (carry[i] & (count[i] ^ INCREMENT[i]));
    end

    assign wrap = carry[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (enable) begin
            count <= sum;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
// Cache-miss fill controller. On a miss it issues eight consecutive 2-byte
// reads covering the 16-byte block, strobes a data-array write for each
// returned word and a single tag-array write with the last word.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : cache_fill_fsm_if.master (miss input, memory handshake, array strobes)
// -----------------------------------------------------------------------------
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_fill_fsm_if.master  bus
);

    // Ones above the block offset, zeros inside it.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(~BLOCK_MASK);

    logic [0:0]        state;
    logic              issue_done;
    logic [ADDR_W-1:0] base;

    logic [2:0] issue_cnt;
    logic       issue_wrap;
    logic [2:0] recv_cnt;
    logic       recv_wrap;

    logic in_fill;
    logic issue_en;
    logic recv_en;
    logic fill_complete;

    assign in_fill       = (state == FILL);
    assign issue_en      = in_fill && !issue_done;
    assign recv_en       = in_fill && bus.memory_data_valid;
    assign fill_complete = recv_en && recv_wrap;

    // Both counters are held at zero in IDLE, so every fill starts at word 0.
    chunk_counter_3b u_issue_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (issue_en),
        .count  (issue_cnt),
        .wrap   (issue_wrap)
    );

    chunk_counter_3b u_recv_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_fill),
        .enable (recv_en),
        .count  (recv_cnt),
        .wrap   (recv_wrap)
    );

    // State, block base and issue-done flag. A miss seen while filling is
    // deliberately ignored; the cache keeps the miss level asserted and it is
    // picked up again once the controller is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_done <= 1'b0;
            base       <= '0;
        end else if (state == IDLE) begin
            if (bus.miss_detected) begin
                state      <= FILL;
                issue_done <= 1'b0;
                base       <= bus.miss_address & BASE_MASK;
            end
        end else begin
            if (fill_complete) begin
                state      <= IDLE;
                issue_done <= 1'b0;
            end else if (issue_en && issue_wrap) begin
                issue_done <= 1'b1;
            end
        end
    end

    // The base has a zero block offset, so OR-ing in the chunk byte offset
    // never carries into the tag/index bits.
    assign bus.fsm_busy         = in_fill;
    assign bus.memory_read      = issue_en;
    assign bus.memory_address   = issue_en
                                  ? (base | {{(ADDR_W-OFFSET_W){1'b0}}, issue_cnt, 1'b0})
                                  : '0;
    assign bus.write_data_array = recv_en;
    assign bus.data_array_word  = recv_en ? recv_cnt : 3'd0;
    assign bus.write_tag_array  = fill_complete;

endmodule
